// File: rtl/mod_seq_if.sv
// Request/response handshake bundle between a requester and the mod sequencer.
interface mod_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [1:0]       rsp_status;

    // Requester / response consumer side
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_status
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_status
    );
endinterface

// File: rtl/mod_seq.sv
// Sequencer in front of the iterative mod unit: launches it, detects
// completion (remainder < divisor), traps divide-by-zero, bounds run time.
module mod_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    mod_seq_if.slave         host,
    output logic             mod_start,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    input  logic [WIDTH-1:0] mod_result,
    output logic             busy
);
    localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DIVZERO = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [WIDTH-1:0] res_q, res_nxt;
    logic [1:0]       sts_q, sts_nxt;
    logic             start_q;
    logic             valid_q;
    logic             busy_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, operand latch, run counter and response capture
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        res_nxt   = res_q;
        sts_nxt   = sts_q;
        case (state)
            S_IDLE: begin
                if (host.req_valid) begin
                    a_nxt = host.req_a;
                    b_nxt = host.req_b;
                    if (host.req_b == '0) begin
                        // Divisor zero: answer immediately, never launch the unit
                        res_nxt   = host.req_a;
                        sts_nxt   = ST_DIVZERO;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (mod_result < b_q) begin
                    res_nxt   = mod_result;
                    sts_nxt   = ST_OK;
                    state_nxt = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    res_nxt   = mod_result;
                    sts_nxt   = ST_TIMEOUT;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (host.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs, decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sts_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            res_q   <= res_nxt;
            sts_q   <= sts_nxt;
            start_q <= (state_nxt == S_LAUNCH);
            valid_q <= (state_nxt == S_DONE);
            busy_q  <= (state_nxt != S_IDLE);
        end
    end

    // Ready is a direct decode of IDLE so it is high during reset
    assign host.req_ready  = (state == S_IDLE);
    assign host.rsp_valid  = valid_q;
    assign host.rsp_result = res_q;
    assign host.rsp_status = sts_q;
    assign mod_start       = start_q;
    assign mod_a           = a_q;
    assign mod_b           = b_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_mod_seq.sv
// Directed bench for mod_seq with a behavioural iterative mod unit and a
// scoreboard of predicted responses.
module tb_mod_seq;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned MAX_CYC = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] result;
        logic [1:0]       status;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             mod_start;
    logic             busy;
    logic [WIDTH-1:0] mod_a;
    logic [WIDTH-1:0] mod_b;
    logic [WIDTH-1:0] mod_result;
    logic [WIDTH-1:0] mod_r;

    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mod_seq_if #(.WIDTH(WIDTH)) bus ();

    mod_seq #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (bus),
        .mod_start  (mod_start),
        .mod_a      (mod_a),
        .mod_b      (mod_b),
        .mod_result (mod_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Amount the mod unit removes per cycle: the largest of 4b, 2b, b that fits
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH+1:0] rw;
        logic [WIDTH+1:0] bw;
        rw = {2'b00, r};
        bw = {2'b00, b};
        if (b == '0) return '0;
        if ((bw << 2) <= rw) return WIDTH'(bw << 2);
        if ((bw << 1) <= rw) return WIDTH'(bw << 1);
        if (bw <= rw) return b;
        return '0;
    endfunction

    // Behavioural mod unit: loads dividend on start, then reduces each cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mod_r <= '0;
        else if (mod_start) mod_r <= mod_a;
        else mod_r <= mod_r - mod_step(mod_r, mod_b);
    end
    assign mod_result = mod_r;

    // Predicted response; lat = clock edges from the accepting edge to rsp_valid.
    // Divide-by-zero enters DONE on the accepting edge itself.
    function automatic exp_t predict(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] r;
        e.a = a;
        e.b = b;
        e.result = '0;
        e.status = 2'b00;
        e.lat = 0;
        if (b == '0) begin
            e.result = a;
            e.status = 2'b01;
            e.lat    = 0;
            return e;
        end
        r = a - mod_step(a, b);
        for (int k = 0; k < int'(MAX_CYC); k++) begin
            if (r < b) begin
                e.result = r;
                e.status = 2'b00;
                e.lat    = 3 + k;
                return e;
            end
            if (k == int'(MAX_CYC) - 1) begin
                e.result = r;
                e.status = 2'b10;
                e.lat    = int'(MAX_CYC) + 2;
                return e;
            end
            r = r - mod_step(r, b);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_mod_start", mod_start, 1'b0);
        chk("rst_mod_a", mod_a, '0);
        chk("rst_mod_b", mod_b, '0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, '0);
        chk("rst_rsp_status", bus.rsp_status, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b1);
    endtask

    // Offer a request until accepted; returns just after the accepting edge
    task automatic do_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int waited;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_wait", bus.req_ready, 1'b1);
        acc_cyc = cyc + 1;
        sb.push_back(predict(a, b));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait for the response, check it, optionally stall and poke req_valid
    task automatic get_rsp(input int hold, input bit poke);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && waited < 3 * int'(MAX_CYC) + 20) begin
            chk("mod_start_run", mod_start, (cyc == acc_cyc) && (sb[0].b != '0));
            chk("mod_a_hold", mod_a, sb[0].a);
            chk("mod_b_hold", mod_b, sb[0].b);
            chk("busy_run", busy, 1'b1);
            chk("req_ready_run", bus.req_ready, 1'b0);
            @(negedge clk);
            waited++;
        end
        e = sb.pop_front();
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        chk("rsp_result", bus.rsp_result, e.result);
        chk("rsp_status", bus.rsp_status, e.status);
        chk("mod_start_done", mod_start, 1'b0);
        chk("busy_done", busy, 1'b1);
        for (int k = 0; k < hold; k++) begin
            if (poke && k == 1) begin
                bus.req_valid = 1'b1;
                bus.req_a     = 32'd1234;
                bus.req_b     = 32'd5;
            end
            if (poke && k == 3) bus.req_valid = 1'b0;
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_result", bus.rsp_result, e.result);
            chk("hold_status", bus.rsp_status, e.status);
            chk("hold_req_ready", bus.req_ready, 1'b0);
            chk("hold_mod_a", mod_a, e.a);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", bus.rsp_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_req_ready", bus.req_ready, 1'b1);
        chk("post_mod_a", mod_a, e.a);
        chk("post_mod_b", mod_b, e.b);
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #3;
        check_reset_values();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // Remainder found on first compare
        do_req(32'd7, 32'd10);
        get_rsp(0, 1'b0);

        // Several reduction cycles
        do_req(32'd100, 32'd7);
        get_rsp(0, 1'b0);

        // Divide-by-zero trap
        do_req(32'd55, 32'd0);
        get_rsp(0, 1'b0);

        // Run-time limit, then a normal request
        do_req(32'd1000, 32'd1);
        get_rsp(0, 1'b0);
        do_req(32'd9, 32'd4);
        get_rsp(0, 1'b0);

        // Back-pressured response with an ignored request during DONE
        do_req(32'd20, 32'd6);
        get_rsp(5, 1'b1);

        // Reset while running
        do_req(32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        #2 reset = 1'b1;
        void'(sb.pop_front());

        // Reset while the start pulse is high
        do_req(32'd30, 32'd4);
        chk("launch_start", mod_start, 1'b1);
        reset = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        #2 reset = 1'b1;
        void'(sb.pop_front());

        // Normal operation after reset
        do_req(32'd10, 32'd3);
        get_rsp(0, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
